game_sequencer: RTL

Match-level controller for the tennis game datapath, clocked on char_clock. It derives a frame tick from vsync and sequences a match: attract, serve, rally, point and game over. During the rally it issues ball-step and paddle-step enables, so the ball/paddle datapath becomes purely step-driven. It also tracks misses and hits, and shortens the ball step period as the rally count grows.

---
 rtl/game_sequencer.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/game_sequencer.sv
// Match-level controller for the tennis datapath: frame tick from vsync, match FSM,
// ball/paddle step enables, miss/hit bookkeeping and rally speed-up.
module game_sequencer #(
  parameter int INIT_PERIOD    = 3,
  parameter int MIN_PERIOD     = 1,
  parameter int HITS_PER_LEVEL = 4,
  parameter int PADDLE_DIV     = 2,
  parameter int SERVE_FRAMES   = 30,
  parameter int POINT_FRAMES   = 60,
  parameter int MAX_MISSES     = 8
) (
  input  logic       char_clock,
  input  logic       reset,
  input  logic       vsync,
  input  logic [3:0] key,
  input  logic       hit,
  input  logic       goal,
  output logic       ball_step,
  output logic       ball_load,
  output logic       paddle_up,
  output logic       paddle_down,
  output logic [2:0] state,
  output logic [3:0] misses,
  output logic [7:0] hits,
  output logic [3:0] period
);

  localparam int FC_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int FC_W   = $clog2(FC_MAX + 1);
  localparam int LVL_W  = $clog2(HITS_PER_LEVEL + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_POINT = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic             vs_s1_q, vs_s1_d, vs_s2_q, vs_s2_d, vs_prev_q, vs_prev_d;
  logic [3:0]       key_s1_q, key_s1_d, key_s2_q, key_s2_d, key_prev_q, key_prev_d;
  logic [3:0]       misses_q, misses_d, period_q, period_d;
  logic [7:0]       hits_q, hits_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [3:0]       step_cnt_q, step_cnt_d, pad_cnt_q, pad_cnt_d;
  logic             ball_step_q, ball_step_d, ball_load_q, ball_load_d;
  logic             paddle_up_q, paddle_up_d, paddle_down_q, paddle_down_d;
  logic             frame_tick, start_press, abort_press, start_match;

  assign frame_tick  = vs_s2_q & ~vs_prev_q;
  assign start_press = key_prev_q[2] & ~key_s2_q[2];
  assign abort_press = key_prev_q[3] & ~key_s2_q[3];

  always_comb begin
    vs_s1_d      = vsync;
    vs_s2_d      = vs_s1_q;
    vs_prev_d    = vs_s2_q;
    key_s1_d     = key;
    key_s2_d     = key_s1_q;
    key_prev_d   = key_s2_q;
    state_d      = state_q;
    misses_d     = misses_q;
    hits_d       = hits_q;
    period_d     = period_q;
    level_d      = level_q;
    frame_cnt_d  = frame_cnt_q;
    step_cnt_d   = step_cnt_q;
    pad_cnt_d    = pad_cnt_q;
    ball_step_d  = 1'b0;
    ball_load_d  = 1'b0;
    paddle_up_d  = 1'b0;
    paddle_down_d = 1'b0;
    start_match  = 1'b0;

    if (abort_press) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_OVER: start_match = start_press;
        S_SERVE: begin
          if (frame_tick) begin
            if (frame_cnt_q == FC_W'(SERVE_FRAMES - 1)) begin
              state_d    = S_PLAY;
              step_cnt_d = '0;
            end else begin
              frame_cnt_d = frame_cnt_q + 1'b1;
            end
          end
        end
        S_PLAY: begin
          // A goal ends the rally outright, so a coincident hit is dropped.
          if (goal) begin
            misses_d = misses_q + 4'd1;
            state_d  = (misses_q + 4'd1 == 4'(MAX_MISSES)) ? S_OVER : S_POINT;
          end else begin
            if (hit) begin
              if (hits_q != 8'hFF) hits_d = hits_q + 8'd1;
              if (level_q == LVL_W'(HITS_PER_LEVEL - 1)) begin
                level_d = '0;
                if (period_q > 4'(MIN_PERIOD)) period_d = period_q - 4'd1;
              end else begin
                level_d = level_q + 1'b1;
              end
            end
            if (start_press) begin
              state_d = S_PAUSE;
            end else if (frame_tick) begin
              if (step_cnt_q + 4'd1 >= period_q) begin
                ball_step_d = 1'b1;
                step_cnt_d  = '0;
              end else begin
                step_cnt_d = step_cnt_q + 4'd1;
              end
            end
          end
        end
        S_PAUSE: if (start_press) state_d = S_PLAY;
        S_POINT: begin
          if (frame_tick) begin
            if (frame_cnt_q == FC_W'(POINT_FRAMES - 1)) begin
              state_d     = S_SERVE;
              ball_load_d = 1'b1;
            end else begin
              frame_cnt_d = frame_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (start_match) begin
      misses_d    = '0;
      hits_d      = '0;
      level_d     = '0;
      period_d    = 4'(INIT_PERIOD);
      ball_load_d = 1'b1;
      state_d     = S_SERVE;
    end

    // Paddle only moves while the match stays in SERVE/PLAY through this cycle.
    if (frame_tick && (state_q == S_SERVE || state_q == S_PLAY) &&
        (state_d == S_SERVE || state_d == S_PLAY)) begin
      if (pad_cnt_q + 4'd1 >= 4'(PADDLE_DIV)) begin
        pad_cnt_d     = '0;
        paddle_up_d   = ~key_s2_q[0];
        paddle_down_d = key_s2_q[0] & ~key_s2_q[1];
      end else begin
        pad_cnt_d = pad_cnt_q + 4'd1;
      end
    end

    if (state_d != state_q) begin
      frame_cnt_d = '0;
      pad_cnt_d   = '0;
    end
  end

  always_ff @(posedge char_clock) begin
    if (reset) begin
      vs_s1_q       <= 1'b0;
      vs_s2_q       <= 1'b0;
      vs_prev_q     <= 1'b0;
      key_s1_q      <= 4'hF;
      key_s2_q      <= 4'hF;
      key_prev_q    <= 4'hF;
      state_q       <= S_IDLE;
      misses_q      <= '0;
      hits_q        <= '0;
      period_q      <= 4'(INIT_PERIOD);
      level_q       <= '0;
      frame_cnt_q   <= '0;
      step_cnt_q    <= '0;
      pad_cnt_q     <= '0;
      ball_step_q   <= 1'b0;
      ball_load_q   <= 1'b0;
      paddle_up_q   <= 1'b0;
      paddle_down_q <= 1'b0;
    end else begin
      vs_s1_q       <= vs_s1_d;
      vs_s2_q       <= vs_s2_d;
      vs_prev_q     <= vs_prev_d;
      key_s1_q      <= key_s1_d;
      key_s2_q      <= key_s2_d;
      key_prev_q    <= key_prev_d;
      state_q       <= state_d;
      misses_q      <= misses_d;
      hits_q        <= hits_d;
      period_q      <= period_d;
      level_q       <= level_d;
      frame_cnt_q   <= frame_cnt_d;
      step_cnt_q    <= step_cnt_d;
      pad_cnt_q     <= pad_cnt_d;
      ball_step_q   <= ball_step_d;
      ball_load_q   <= ball_load_d;
      paddle_up_q   <= paddle_up_d;
      paddle_down_q <= paddle_down_d;
    end
  end

  assign ball_step   = ball_step_q;
  assign ball_load   = ball_load_q;
  assign paddle_up   = paddle_up_q;
  assign paddle_down = paddle_down_q;
  assign state       = state_q;
  assign misses      = misses_q;
  assign hits        = hits_q;
  assign period      = period_q;

endmodule
